// File: rtl/divisor_freq_multi.sv
// divisor_freq_multi: multi-channel programmable tick / square-wave generator on CLK_50
//
// Each channel counts enabled CLK_50 edges modulo its divisor D and wraps every D
// edges. On a wrap it emits a one-cycle TICK. In square mode it also toggles SQW,
// which gives a 50 % duty wave of period 2*D. Every output is registered.
//
// Ports:
//   CLK_50   system clock; all logic runs on its rising edge
//   RST      synchronous active-high reset; loads DEFAULT_DIV and pulse mode into every channel
//   EN       per-channel run enable; while low the count and SQW hold
//   WR_EN    configuration write strobe
//   WR_CH    channel addressed by the write; values >= CHANNELS are ignored
//   WR_DIV   new divisor D (0 halts the channel)
//   WR_MODE  new mode: 0 = pulse, 1 = square
//   TICK     per-channel one-cycle pulse on counter wrap
//   SQW      per-channel square wave (stays 0 in pulse mode)
module divisor_freq_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic                        CLK_50,
    input  logic                        RST,
    input  logic [CHANNELS-1:0]         EN,
    input  logic                        WR_EN,
    input  logic [$clog2(CHANNELS)-1:0] WR_CH,
    input  logic [WIDTH-1:0]            WR_DIV,
    input  logic                        WR_MODE,
    output logic [CHANNELS-1:0]         TICK,
    output logic [CHANNELS-1:0]         SQW
);
    localparam int CW = $clog2(CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] div_q, cnt_q;
        logic             mode_q, tick_q, sqw_q;
        logic             wr_hit, run, wrap;
        // An out-of-range WR_CH never matches any channel, so that write changes nothing.
        // A divisor of 0 never runs, which keeps the channel halted with CNT at 0.
        always_comb begin
            wr_hit = WR_EN && (WR_CH == CW'(i));
            run    = EN[i] && (div_q != '0);
            wrap   = cnt_q == div_q - WIDTH'(1);
        end
        // A write beats counting on the same edge, so a wrap on that edge is lost on purpose.
        always_ff @(posedge CLK_50) begin
            if (RST) begin
                div_q  <= WIDTH'(DEFAULT_DIV);
                mode_q <= 1'b0;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                sqw_q  <= 1'b0;
            end else if (wr_hit) begin
                div_q  <= WR_DIV;
                mode_q <= WR_MODE;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                sqw_q  <= 1'b0;
            end else begin
                tick_q <= run && wrap;
                if (run) begin
                    cnt_q <= wrap ? '0 : cnt_q + WIDTH'(1);
                    if (wrap && mode_q)
                        sqw_q <= ~sqw_q;
                end
            end
        end
        assign TICK[i] = tick_q;
        assign SQW[i]  = sqw_q;
    end
endmodule

// File: tb/tb_divisor_freq_multi.sv
// tb_divisor_freq_multi: directed checks of divisor_freq_multi (4-channel and 5-channel builds)
module tb_divisor_freq_multi;
    logic       CLK_50 = 1'b0;
    logic       RST    = 1'b1;
    logic [3:0] en      = '0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_ch   = '0;
    logic [7:0] wr_div  = '0;
    logic       wr_mode = 1'b0;
    logic [3:0] tick, sqw;
    logic [4:0] en2      = '0;
    logic       wr_en2   = 1'b0;
    logic [2:0] wr_ch2   = '0;
    logic [7:0] wr_div2  = '0;
    logic       wr_mode2 = 1'b0;
    logic [4:0] tick2, sqw2;
    int checks = 0;
    int errors = 0;

    always #5 CLK_50 = ~CLK_50;

    divisor_freq_multi #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(5)) dut (
        .CLK_50(CLK_50), .RST(RST), .EN(en), .WR_EN(wr_en), .WR_CH(wr_ch),
        .WR_DIV(wr_div), .WR_MODE(wr_mode), .TICK(tick), .SQW(sqw)
    );

    divisor_freq_multi #(.CHANNELS(5), .WIDTH(8), .DEFAULT_DIV(3)) dut5 (
        .CLK_50(CLK_50), .RST(RST), .EN(en2), .WR_EN(wr_en2), .WR_CH(wr_ch2),
        .WR_DIV(wr_div2), .WR_MODE(wr_mode2), .TICK(tick2), .SQW(sqw2)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [7:0] d, input logic m);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = d;
        wr_mode = m;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        check("rst_tick", 8'(tick), 8'h00);
        check("rst_sqw", 8'(sqw), 8'h00);
        check("rst_tick5", 8'(tick2), 8'h00);
        RST = 1'b0;
        en  = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("dflt_tick_e%0d", k), 8'(tick), (k % 5 == 0) ? 8'h01 : 8'h00);
            check($sformatf("dflt_sqw_e%0d", k), 8'(sqw), 8'h00);
        end
        en = 4'b0010;
        write_cfg(2'd1, 8'd3, 1'b1);
        check("sq_wr_tick", 8'(tick), 8'h00);
        check("sq_wr_sqw", 8'(sqw), 8'h00);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("sq_tick_e%0d", k), 8'(tick), (k % 3 == 0) ? 8'h02 : 8'h00);
            check($sformatf("sq_sqw_e%0d", k), 8'(sqw), ((k / 3) % 2 == 1) ? 8'h02 : 8'h00);
        end
        en = 4'b0001;
        write_cfg(2'd0, 8'd4, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            step();
            check($sformatf("gate_pre_e%0d", k), 8'(tick), 8'h00);
        end
        en = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("gate_hold_c%0d", k), 8'(tick), 8'h00);
            check($sformatf("gate_sqw_c%0d", k), 8'(sqw), 8'h00);
        end
        en = 4'b0001;
        step();
        check("gate_resume_e1", 8'(tick), 8'h00);
        step();
        check("gate_resume_e2", 8'(tick), 8'h01);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("gate_post_e%0d", k), 8'(tick), (k == 4) ? 8'h01 : 8'h00);
        end
        en = 4'b0100;
        write_cfg(2'd2, 8'd4, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("coll_pre_e%0d", k), 8'(tick), 8'h00);
        end
        write_cfg(2'd2, 8'd6, 1'b0);
        check("coll_edge", 8'(tick), 8'h00);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("coll_post_e%0d", k), 8'(tick), (k == 6) ? 8'h04 : 8'h00);
        end
        en = 4'b1000;
        write_cfg(2'd3, 8'd1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("d1_tick_e%0d", k), 8'(tick), 8'h08);
            check($sformatf("d1_sqw_e%0d", k), 8'(sqw), 8'h00);
        end
        write_cfg(2'd3, 8'd1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("d1sq_tick_e%0d", k), 8'(tick), 8'h08);
            check($sformatf("d1sq_sqw_e%0d", k), 8'(sqw), (k % 2 == 1) ? 8'h08 : 8'h00);
        end
        write_cfg(2'd3, 8'd0, 1'b1);
        check("d0_wr_sqw", 8'(sqw), 8'h00);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("d0_tick_c%0d", k), 8'(tick), 8'h00);
            check($sformatf("d0_sqw_c%0d", k), 8'(sqw), 8'h00);
        end
        en2      = 5'b11111;
        wr_en2   = 1'b1;
        wr_ch2   = 3'd5;
        wr_div2  = 8'd1;
        wr_mode2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) wr_ch2 = 3'd7;
            step();
            check($sformatf("oor_tick_e%0d", k), 8'(tick2), (k % 3 == 0) ? 8'h1f : 8'h00);
            check($sformatf("oor_sqw_e%0d", k), 8'(sqw2), 8'h00);
        end
        wr_ch2 = 3'd4;
        step();
        wr_en2 = 1'b0;
        check("ch4_wr_tick", 8'(tick2), 8'h00);
        step();
        check("ch4_d1_tick", 8'(tick2), 8'h10);
        check("ch4_d1_sqw", 8'(sqw2), 8'h10);
        en = 4'b0000;
        write_cfg(2'd0, 8'd2, 1'b1);
        write_cfg(2'd1, 8'd2, 1'b1);
        en = 4'b0011;
        step();
        check("mid_pre_tick1", 8'(tick), 8'h00);
        step();
        check("mid_pre_tick2", 8'(tick), 8'h03);
        check("mid_pre_sqw2", 8'(sqw), 8'h03);
        RST = 1'b1;
        step();
        check("mid_rst_tick", 8'(tick), 8'h00);
        check("mid_rst_sqw", 8'(sqw), 8'h00);
        RST = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("mid_post_tick_e%0d", k), 8'(tick), (k == 5) ? 8'h03 : 8'h00);
            check($sformatf("mid_post_sqw_e%0d", k), 8'(sqw), 8'h00);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
